// File: rtl/branch_cmp_pipe.sv
// Pipelined branch comparator: ten signed/unsigned conditions, STAGES register
// stages with valid/ready back-pressure and flush. Define CMP_STATS_EN for counters.
module branch_cmp_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [4:0]       flags,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef CMP_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [15:0]      stat_total,
    output logic [15:0]      stat_taken
`endif
);

    typedef struct packed {
        logic             taken;
        logic [4:0]       flags;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic eq, lt_s, lt_u, a_zero, a_neg;
    res_t res_in;

    always_comb begin
        eq     = (a == b);
        lt_s   = ($signed(a) < $signed(b));
        lt_u   = (a < b);
        a_zero = (a == '0);
        a_neg  = a[WIDTH-1];
        res_in         = '0;
        res_in.flags   = {eq, lt_s, lt_u, a_zero, a_neg};
        res_in.tag     = in_tag;
        case (op)
            4'd0:    res_in.taken = eq;
            4'd1:    res_in.taken = !eq;
            4'd2:    res_in.taken = a_neg || a_zero;
            4'd3:    res_in.taken = !a_neg && !a_zero;
            4'd4:    res_in.taken = a_neg;
            4'd5:    res_in.taken = !a_neg;
            4'd6:    res_in.taken = lt_s;
            4'd7:    res_in.taken = lt_u;
            4'd8:    res_in.taken = !lt_s;
            4'd9:    res_in.taken = !lt_u;
            default: res_in.illegal = 1'b1;
        endcase
    end

    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] rdy;
    res_t [STAGES:1] stg;

    for (genvar i = 1; i <= STAGES; i++) begin : g_stg
        logic up_v;
        res_t up_r;

        if (i == 1) begin : g_first
            assign up_v = in_valid;
            assign up_r = res_in;
        end else begin : g_next
            assign up_v = vld_pipe[i-1];
            assign up_r = stg[i-1];
        end

        // A stage can load when any stage from here to the output has a hole,
        // or the output is draining; equivalent to the rdy chain without a loop.
        assign rdy[i] = out_ready || !(&vld_pipe[STAGES:i]);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_pipe[i] <= 1'b0;
                stg[i]      <= '0;
            end else begin
                if (rdy[i])
                    stg[i] <= up_r;
                if (flush)
                    vld_pipe[i] <= 1'b0;
                else if (rdy[i])
                    vld_pipe[i] <= up_v;
            end
        end
    end

    assign in_ready  = rdy[1];
    assign out_valid = vld_pipe[STAGES];
    assign taken     = stg[STAGES].taken;
    assign flags     = stg[STAGES].flags;
    assign illegal   = stg[STAGES].illegal;
    assign out_tag   = stg[STAGES].tag;

`ifdef CMP_STATS_EN
    logic hs;
    assign hs = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_total <= '0;
            stat_taken <= '0;
        end else if (stat_clr) begin
            stat_total <= '0;
            stat_taken <= '0;
        end else if (hs) begin
            if (stat_total != 16'hFFFF)
                stat_total <= stat_total + 16'd1;
            if (taken && stat_taken != 16'hFFFF)
                stat_taken <= stat_taken + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Directed bench for branch_cmp_pipe: three instances (STAGES=1,2,3) share stimulus;
// each task checks the instance relevant to its scenario.
module tb_branch_cmp_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        stat_clr = 1'b0;

    logic       ir1, ov1, tk1, il1;
    logic [4:0] fl1, tg1;
    logic       ir2, ov2, tk2, il2;
    logic [4:0] fl2, tg2;
    logic       ir3, ov3, tk3, il3;
    logic [4:0] fl3, tg3;
    logic [15:0] st1_tot, st1_tkn, st2_tot, st2_tkn, st3_tot, st3_tkn;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_cmp_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(5)) d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .op(op), .a(a), .b(b),
        .in_tag(in_tag), .flush(flush), .out_valid(ov1), .out_ready(out_ready), .taken(tk1),
        .flags(fl1), .illegal(il1), .out_tag(tg1)
`ifdef CMP_STATS_EN
        , .stat_clr(stat_clr), .stat_total(st1_tot), .stat_taken(st1_tkn)
`endif
    );

    branch_cmp_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .op(op), .a(a), .b(b),
        .in_tag(in_tag), .flush(flush), .out_valid(ov2), .out_ready(out_ready), .taken(tk2),
        .flags(fl2), .illegal(il2), .out_tag(tg2)
`ifdef CMP_STATS_EN
        , .stat_clr(stat_clr), .stat_total(st2_tot), .stat_taken(st2_tkn)
`endif
    );

    branch_cmp_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(5)) d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir3), .op(op), .a(a), .b(b),
        .in_tag(in_tag), .flush(flush), .out_valid(ov3), .out_ready(out_ready), .taken(tk3),
        .flags(fl3), .illegal(il3), .out_tag(tg3)
`ifdef CMP_STATS_EN
        , .stat_clr(stat_clr), .stat_total(st3_tot), .stat_taken(st3_tkn)
`endif
    );

`ifndef CMP_STATS_EN
    assign st1_tot = '0; assign st1_tkn = '0;
    assign st2_tot = '0; assign st2_tkn = '0;
    assign st3_tot = '0; assign st3_tkn = '0;
`endif

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        tests++;
        if ({ov1, tk1, fl1, il1, tg1} !== 13'd0) begin
            fails++; $display("FAIL reset_outputs got %b want 0", {ov1, tk1, fl1, il1, tg1});
        end
        tests++;
        if ({ov2, ov3} !== 2'b00) begin
            fails++; $display("FAIL reset_valid23 got %b want 00", {ov2, ov3});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        step();
        tests++;
        if ({ir1, ir2, ir3} !== 3'b111) begin
            fails++; $display("FAIL reset_in_ready got %b want 111", {ir1, ir2, ir3});
        end
    endtask

    task automatic test_basic;
        apply_reset();
        in_valid = 1'b1; op = 4'd0; a = 32'h0000_1234; b = 32'h0000_1234; in_tag = 5'd3;
        out_ready = 1'b1;
        #1;
        tests++;
        if (ov1 !== 1'b0) begin
            fails++; $display("FAIL basic_pre_valid got %b want 0", ov1);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if ({ov1, tk1, fl1, il1, tg1} !== {1'b1, 1'b1, 5'b10000, 1'b0, 5'd3}) begin
            fails++;
            $display("FAIL basic_eq got v=%b t=%b f=%b i=%b tag=%0d want v=1 t=1 f=10000 i=0 tag=3",
                     ov1, tk1, fl1, il1, tg1);
        end
    endtask

    task automatic test_signed;
        logic [3:0] ops  [10] = '{4'd6, 4'd7, 4'd4, 4'd2, 4'd8, 4'd9, 4'd5, 4'd3, 4'd1, 4'd0};
        logic       want [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        a = 32'hFFFF_FFFF; b = 32'd1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = ops[i]; in_tag = 5'(i);
            step();
            tests++;
            if ({ov1, tk1, fl1, il1, tg1} !== {1'b1, want[i], 5'b01001, 1'b0, 5'(i)}) begin
                fails++;
                $display("FAIL signed_op%0d got v=%b t=%b f=%b i=%b tag=%0d want v=1 t=%b f=01001 i=0 tag=%0d",
                         ops[i], ov1, tk1, fl1, il1, tg1, want[i], i);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal;
        apply_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; op = 4'd12; a = 32'h8000_0000; b = 32'h7FFF_FFFF; in_tag = 5'd9;
        step();
        tests++;
        if ({ov1, tk1, il1, tg1} !== {1'b1, 1'b0, 1'b1, 5'd9}) begin
            fails++; $display("FAIL illegal_op12 got v=%b t=%b i=%b tag=%0d want v=1 t=0 i=1 tag=9",
                              ov1, tk1, il1, tg1);
        end
        op = 4'd15; in_tag = 5'd10;
        step();
        tests++;
        if ({tk1, il1} !== 2'b01) begin
            fails++; $display("FAIL illegal_op15 got t=%b i=%b want t=0 i=1", tk1, il1);
        end
        op = 4'd3; a = 32'd0; b = 32'd5; in_tag = 5'd11;
        step();
        in_valid = 1'b0;
        tests++;
        if ({ov1, tk1, fl1, il1} !== {1'b1, 1'b0, 5'b01110, 1'b0}) begin
            fails++; $display("FAIL gtz_zero got v=%b t=%b f=%b i=%b want v=1 t=0 f=01110 i=0",
                              ov1, tk1, fl1, il1);
        end
    endtask

    task automatic test_back_to_back;
        int k = 0;
        int exp = 0;
        int c = 0;
        logic hold_chk = 1'b0;
        logic [11:0] held = '0;
        apply_reset();
        while (exp < 8 && c < 60) begin
            out_ready = !(c >= 4 && c <= 9);
            in_valid = (k < 8); op = 4'd0; a = 32'(k); b = 32'd2; in_tag = 5'(k);
            #1;
            if (hold_chk) begin
                tests++;
                if ({ov3, tk3, fl3, il3, tg3} !== {1'b1, held}) begin
                    fails++; $display("FAIL b2b_stall_stable cyc=%0d got %b want %b",
                                      c, {ov3, tk3, fl3, il3, tg3}, {1'b1, held});
                end
            end
            if (c == 5) begin
                tests++;
                if (ir3 !== 1'b0) begin
                    fails++; $display("FAIL b2b_full_in_ready got %b want 0", ir3);
                end
            end
            if (ov3 && out_ready) begin
                tests++;
                if ({tg3, tk3} !== {5'(exp), exp == 2}) begin
                    fails++; $display("FAIL b2b_order got tag=%0d t=%b want tag=%0d t=%b",
                                      tg3, tk3, exp, exp == 2);
                end
                exp++;
            end
            hold_chk = ov3 && !out_ready;
            held = {tk3, fl3, il3, tg3};
            if (in_valid && ir3) k++;
            step();
            c++;
        end
        in_valid = 1'b0;
        tests++;
        if (exp != 8 || k != 8) begin
            fails++; $display("FAIL b2b_count got out=%0d in=%0d want 8 8", exp, k);
        end
        repeat (3) step();
        tests++;
        if (ov3 !== 1'b0) begin
            fails++; $display("FAIL b2b_no_dup got v=%b want 0", ov3);
        end
    endtask

    task automatic test_flush;
        int seen = 0;
        apply_reset();
        out_ready = 1'b0; op = 4'd0; a = '0; b = '0;
        in_valid = 1'b1; in_tag = 5'd10;
        step();
        in_tag = 5'd11;
        step();
        in_tag = 5'd12; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ov2) seen++;
            step();
        end
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL flush_kill got %0d valid cycles want 0", seen);
        end
        in_valid = 1'b1; in_tag = 5'd13;
        step();
        in_valid = 1'b0;
        tests++;
        if (ov2 !== 1'b0) begin
            fails++; $display("FAIL flush_lat1 got v=%b want 0", ov2);
        end
        step();
        tests++;
        if ({ov2, tg2} !== {1'b1, 5'd13}) begin
            fails++; $display("FAIL flush_lat2 got v=%b tag=%0d want v=1 tag=13", ov2, tg2);
        end
    endtask

`ifdef CMP_STATS_EN
    task automatic test_stats;
        apply_reset();
        out_ready = 1'b1; op = 4'd0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; a = 32'(i); b = (i % 3 == 0) ? 32'(i) : 32'(i + 100); in_tag = 5'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        tests++;
        if ({st1_tot, st1_tkn} !== {16'd20, 16'd7}) begin
            fails++; $display("FAIL stats_count got tot=%0d tkn=%0d want 20 7", st1_tot, st1_tkn);
        end
        in_valid = 1'b1; a = 32'd1; b = 32'd1;
        step();
        in_valid = 1'b0; stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        tests++;
        if ({st1_tot, st1_tkn} !== 32'd0) begin
            fails++; $display("FAIL stats_clr got tot=%0d tkn=%0d want 0 0", st1_tot, st1_tkn);
        end
        in_valid = 1'b1;
        repeat (3) step();
        tests++;
        if (st1_tot !== 16'd2) begin
            fails++; $display("FAIL stats_restart got tot=%0d want 2", st1_tot);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({st1_tot, st1_tkn, ov1} !== 33'd0) begin
            fails++; $display("FAIL stats_reset got tot=%0d tkn=%0d v=%b want 0 0 0",
                              st1_tot, st1_tkn, ov1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_illegal();
        test_back_to_back();
        test_flush();
`ifdef CMP_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
